// File: rtl/smu_hold_tracker_pkg.sv
// Shared definitions for the SMU hold tracker.
// Contents: the FSM state encoding, the record field widths, the entry-count
// saturation constant, and the sat63 helper that clamps num_entries into a
// 6-bit record field.
package smu_hold_tracker_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int NUM_ENTRIES_W = 30;
  localparam int ENTRIES_W     = 6;
  localparam int SAT_ENTRIES   = 63;

  // Clamp the stack-cache entry count so that it fits the 6-bit record field.
  function automatic logic [ENTRIES_W-1:0] sat63(input logic [NUM_ENTRIES_W-1:0] n);
    if (n > NUM_ENTRIES_W'(SAT_ENTRIES)) begin
      return ENTRIES_W'(SAT_ENTRIES);
    end
    return n[ENTRIES_W-1:0];
  endfunction

endpackage

// File: rtl/smu_hold_tracker_if.sv
// Record handshake bundle between the hold tracker and its consumer.
//   rec_valid   : head record available (producer -> consumer)
//   rec_ready   : consumer accepts the head record (consumer -> producer)
//   rec_len     : head record, hold episode length in cycles
//   rec_entries : head record, saturated num_entries at episode start
// The master modport belongs to the tracker. The slave modport belongs to the consumer.
interface smu_hold_tracker_if
  import smu_hold_tracker_pkg::*;
#(
  parameter int LEN_W = 16
) ();

  logic                 rec_valid;
  logic                 rec_ready;
  logic [LEN_W-1:0]     rec_len;
  logic [ENTRIES_W-1:0] rec_entries;

  modport master (
    output rec_valid,
    output rec_len,
    output rec_entries,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_len,
    input  rec_entries,
    output rec_ready
  );

endinterface

// File: rtl/smu_hold_tracker_rec_fifo.sv
// smu_hold_rec_fifo: a small synchronous FIFO that holds hold-episode records.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   i_push, i_din   : write request and record data
//   i_pop           : remove the head record
//   o_full, o_empty : occupancy flags (both taken from the registered count)
//   o_dout          : head record; zero while the FIFO is empty
// When the FIFO is full, a push is still accepted if a pop happens in the same
// cycle. A push into an empty FIFO becomes visible on the next cycle, so the
// record never passes straight through.
module smu_hold_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd_en = i_pop & ~o_empty;
  // When the FIFO is full, wr_ptr equals rd_ptr. The entry being overwritten is
  // the head that is leaving in this same cycle.
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Gating the head with empty makes it read zero after reset, even though the storage itself is never cleared.
  assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/smu_hold_tracker.sv
// smu_hold_tracker: measures SMU hold episodes and queues one record per episode.
// Ports:
//   pj_clk, pj_reset : clock and asynchronous active-high reset
//   smu_hold         : hold indication, sampled every cycle
//   num_entries      : current stack-cache entry count
//   rec              : record handshake (valid/ready, len, entries)
//   episode_count    : number of completed episodes, including dropped ones (wraps)
//   hold_cycles      : number of cycles with smu_hold=1 (wraps)
//   drop_count       : number of records lost to a full FIFO (saturates)
module smu_hold_tracker
  import smu_hold_tracker_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic                     pj_clk,
  input  logic                     pj_reset,
  input  logic                     smu_hold,
  input  logic [NUM_ENTRIES_W-1:0] num_entries,
  smu_hold_tracker_if.master       rec,
  output logic [31:0]              episode_count,
  output logic [31:0]              hold_cycles,
  output logic [15:0]              drop_count
);

  localparam int               REC_W   = LEN_W + ENTRIES_W;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_W-1:0]     r_len_cnt;
  logic [ENTRIES_W-1:0] r_start_entries;
  logic [31:0]          r_episode_count;
  logic [31:0]          r_hold_cycles;
  logic [15:0]          r_drop_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [REC_W-1:0]     w_head;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: if (smu_hold) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!smu_hold) begin
          w_state_nxt = ST_IDLE;
          w_push      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // The episode length counter starts at 1 on entry to HOLD and stops at all-ones instead of wrapping.
  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) begin
      r_len_cnt       <= '0;
      r_start_entries <= '0;
    end else if (r_state == ST_IDLE && smu_hold) begin
      r_len_cnt       <= LEN_W'(1);
      r_start_entries <= sat63(num_entries);
    end else if (r_state == ST_HOLD && smu_hold && r_len_cnt != LEN_MAX) begin
      r_len_cnt <= r_len_cnt + LEN_W'(1);
    end
  end

  assign w_pop  = rec.rec_valid & rec.rec_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) begin
      r_episode_count <= '0;
      r_hold_cycles   <= '0;
      r_drop_count    <= '0;
    end else begin
      if (w_push)   r_episode_count <= r_episode_count + 32'd1;
      if (smu_hold) r_hold_cycles   <= r_hold_cycles + 32'd1;
      if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  smu_hold_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (pj_clk),
    .rst     (pj_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({r_len_cnt, r_start_entries}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_head)
  );

  assign rec.rec_valid   = ~w_empty;
  assign rec.rec_len     = w_head[REC_W-1:ENTRIES_W];
  assign rec.rec_entries = w_head[ENTRIES_W-1:0];
  assign episode_count   = r_episode_count;
  assign hold_cycles     = r_hold_cycles;
  assign drop_count      = r_drop_count;

endmodule

// File: tb/tb_smu_hold_tracker.sv
// Directed testbench for smu_hold_tracker. It uses two instances that share
// the same stimulus: LEN_W=16 (the main DUT) and LEN_W=4 (for length saturation).
module tb_smu_hold_tracker;
  import smu_hold_tracker_pkg::*;

  logic        pj_clk = 1'b0;
  logic        pj_reset = 1'b1;
  logic        smu_hold = 1'b0;
  logic [29:0] num_entries = '0;
  logic [31:0] ep16, hc16, ep4, hc4;
  logic [15:0] dc16, dc4;
  int          n_total = 0;
  int          n_bad = 0;

  smu_hold_tracker_if #(.LEN_W(16)) rif16 ();
  smu_hold_tracker_if #(.LEN_W(4))  rif4 ();

  smu_hold_tracker #(.FIFO_DEPTH(4), .LEN_W(16)) dut16 (
    .pj_clk(pj_clk), .pj_reset(pj_reset), .smu_hold(smu_hold),
    .num_entries(num_entries), .rec(rif16),
    .episode_count(ep16), .hold_cycles(hc16), .drop_count(dc16)
  );

  smu_hold_tracker #(.FIFO_DEPTH(4), .LEN_W(4)) dut4 (
    .pj_clk(pj_clk), .pj_reset(pj_reset), .smu_hold(smu_hold),
    .num_entries(num_entries), .rec(rif4),
    .episode_count(ep4), .hold_cycles(hc4), .drop_count(dc4)
  );

  always #5 pj_clk = ~pj_clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  task automatic cycle();
    @(posedge pj_clk);
    #1;
  endtask

  task automatic do_reset();
    pj_reset = 1'b1;
    smu_hold = 1'b0;
    rif16.rec_ready = 1'b0;
    cycle();
    cycle();
    pj_reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rif16.rec_ready = 1'b0;
    rif4.rec_ready  = 1'b1;
    pj_reset = 1'b1;
    cycle();
    cycle();
    n_total++; if (rif16.rec_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0d want=0", rif16.rec_valid); end
    n_total++; if (rif16.rec_len !== 16'd0) begin n_bad++; $display("FAIL rst_len got=%0d want=0", rif16.rec_len); end
    n_total++; if (rif16.rec_entries !== 6'd0) begin n_bad++; $display("FAIL rst_entries got=%0d want=0", rif16.rec_entries); end
    n_total++; if (ep16 !== 32'd0) begin n_bad++; $display("FAIL rst_episode got=%0d want=0", ep16); end
    n_total++; if (hc16 !== 32'd0) begin n_bad++; $display("FAIL rst_hold_cycles got=%0d want=0", hc16); end
    n_total++; if (dc16 !== 16'd0) begin n_bad++; $display("FAIL rst_drop got=%0d want=0", dc16); end
    pj_reset = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    do_reset();
    rif16.rec_ready = 1'b1;
    num_entries = 30'd20;
    smu_hold = 1'b1;
    repeat (5) cycle();
    n_total++; if (rif16.rec_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_early_valid got=%0d want=0", rif16.rec_valid); end
    smu_hold = 1'b0;
    cycle();
    n_total++; if (rif16.rec_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%0d want=1", rif16.rec_valid); end
    n_total++; if (rif16.rec_len !== 16'd5) begin n_bad++; $display("FAIL basic_len got=%0d want=5", rif16.rec_len); end
    n_total++; if (rif16.rec_entries !== 6'd20) begin n_bad++; $display("FAIL basic_entries got=%0d want=20", rif16.rec_entries); end
    n_total++; if (ep16 !== 32'd1) begin n_bad++; $display("FAIL basic_episode got=%0d want=1", ep16); end
    n_total++; if (hc16 !== 32'd5) begin n_bad++; $display("FAIL basic_hold_cycles got=%0d want=5", hc16); end
    cycle();
    n_total++; if (rif16.rec_valid !== 1'b0) begin n_bad++; $display("FAIL basic_popped got=%0d want=0", rif16.rec_valid); end
  endtask

  task automatic test_sat();
    do_reset();
    rif16.rec_ready = 1'b1;
    num_entries = 30'd100;
    smu_hold = 1'b1;
    cycle();
    smu_hold = 1'b0;
    cycle();
    n_total++; if (rif16.rec_len !== 16'd1) begin n_bad++; $display("FAIL sat100_len got=%0d want=1", rif16.rec_len); end
    n_total++; if (rif16.rec_entries !== 6'd63) begin n_bad++; $display("FAIL sat100_entries got=%0d want=63", rif16.rec_entries); end
    num_entries = 30'd64;
    smu_hold = 1'b1;
    cycle();
    smu_hold = 1'b0;
    cycle();
    n_total++; if (rif16.rec_entries !== 6'd63) begin n_bad++; $display("FAIL sat64_entries got=%0d want=63", rif16.rec_entries); end
    num_entries = 30'd62;
    smu_hold = 1'b1;
    cycle();
    smu_hold = 1'b0;
    cycle();
    n_total++; if (rif16.rec_entries !== 6'd62) begin n_bad++; $display("FAIL sat62_entries got=%0d want=62", rif16.rec_entries); end
    cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    rif16.rec_ready = 1'b0;
    num_entries = 30'd5;
    smu_hold = 1'b1;
    cycle();
    smu_hold = 1'b0;
    cycle();
    num_entries = 30'd7;
    smu_hold = 1'b1;
    cycle();
    cycle();
    smu_hold = 1'b0;
    cycle();
    cycle();
    n_total++; if (ep16 !== 32'd2) begin n_bad++; $display("FAIL b2b_episode got=%0d want=2", ep16); end
    n_total++; if ({rif16.rec_len, rif16.rec_entries} !== {16'd1, 6'd5}) begin n_bad++; $display("FAIL b2b_head0 got=%0d/%0d want=1/5", rif16.rec_len, rif16.rec_entries); end
    rif16.rec_ready = 1'b1;
    cycle();
    n_total++; if ({rif16.rec_len, rif16.rec_entries} !== {16'd2, 6'd7}) begin n_bad++; $display("FAIL b2b_head1 got=%0d/%0d want=2/7", rif16.rec_len, rif16.rec_entries); end
    cycle();
    n_total++; if (rif16.rec_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got=%0d want=0", rif16.rec_valid); end
    rif16.rec_ready = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    rif16.rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      num_entries = 30'(10 + i);
      smu_hold = 1'b1;
      cycle();
      cycle();
      smu_hold = 1'b0;
      cycle();
    end
    n_total++; if (rif16.rec_valid !== 1'b1) begin n_bad++; $display("FAIL drop_valid got=%0d want=1", rif16.rec_valid); end
    n_total++; if (dc16 !== 16'd2) begin n_bad++; $display("FAIL drop_count got=%0d want=2", dc16); end
    n_total++; if (ep16 !== 32'd6) begin n_bad++; $display("FAIL drop_episode got=%0d want=6", ep16); end
    n_total++; if (hc16 !== 32'd12) begin n_bad++; $display("FAIL drop_hold_cycles got=%0d want=12", hc16); end
    rif16.rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (rif16.rec_valid !== 1'b1 || rif16.rec_len !== 16'd2 || rif16.rec_entries !== 6'(10 + k)) begin
        n_bad++;
        $display("FAIL drop_order%0d got=%0d/%0d/%0d want=1/2/%0d", k, rif16.rec_valid, rif16.rec_len, rif16.rec_entries, 10 + k);
      end
      cycle();
    end
    n_total++; if (rif16.rec_valid !== 1'b0) begin n_bad++; $display("FAIL drop_drained got=%0d want=0", rif16.rec_valid); end
    rif16.rec_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    rif16.rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      num_entries = 30'(20 + i);
      smu_hold = 1'b1;
      cycle();
      cycle();
      smu_hold = 1'b0;
      cycle();
    end
    num_entries = 30'd24;
    smu_hold = 1'b1;
    cycle();
    cycle();
    smu_hold = 1'b0;
    rif16.rec_ready = 1'b1;
    cycle();
    rif16.rec_ready = 1'b0;
    n_total++; if (dc16 !== 16'd0) begin n_bad++; $display("FAIL fullpop_drop got=%0d want=0", dc16); end
    n_total++; if (ep16 !== 32'd5) begin n_bad++; $display("FAIL fullpop_episode got=%0d want=5", ep16); end
    cycle();
    rif16.rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (rif16.rec_valid !== 1'b1 || rif16.rec_entries !== 6'(21 + k)) begin
        n_bad++;
        $display("FAIL fullpop_rec%0d got=%0d/%0d want=1/%0d", k, rif16.rec_valid, rif16.rec_entries, 21 + k);
      end
      cycle();
    end
    n_total++; if (rif16.rec_valid !== 1'b0) begin n_bad++; $display("FAIL fullpop_drained got=%0d want=0", rif16.rec_valid); end
    rif16.rec_ready = 1'b0;
  endtask

  task automatic test_len_sat();
    do_reset();
    rif16.rec_ready = 1'b0;
    num_entries = 30'd3;
    smu_hold = 1'b1;
    repeat (20) cycle();
    smu_hold = 1'b0;
    cycle();
    n_total++; if (rif4.rec_valid !== 1'b1) begin n_bad++; $display("FAIL lensat_valid got=%0d want=1", rif4.rec_valid); end
    n_total++; if (rif4.rec_len !== 4'd15) begin n_bad++; $display("FAIL lensat_len4 got=%0d want=15", rif4.rec_len); end
    n_total++; if (hc4 !== 32'd20) begin n_bad++; $display("FAIL lensat_hold_cycles got=%0d want=20", hc4); end
    n_total++; if (rif16.rec_len !== 16'd20) begin n_bad++; $display("FAIL lensat_len16 got=%0d want=20", rif16.rec_len); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rif16.rec_ready = 1'b0;
    num_entries = 30'd9;
    smu_hold = 1'b1;
    repeat (3) cycle();
    pj_reset = 1'b1;
    #1;
    n_total++; if ({rif16.rec_valid, rif16.rec_len, rif16.rec_entries} !== '0) begin n_bad++; $display("FAIL midrst_rec got=%0d/%0d/%0d want=0/0/0", rif16.rec_valid, rif16.rec_len, rif16.rec_entries); end
    n_total++; if ({ep16, hc16, dc16} !== '0) begin n_bad++; $display("FAIL midrst_counters got=%0d/%0d/%0d want=0/0/0", ep16, hc16, dc16); end
    smu_hold = 1'b0;
    cycle();
    pj_reset = 1'b0;
    cycle();
    cycle();
    n_total++; if (rif16.rec_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_record got=%0d want=0", rif16.rec_valid); end
    smu_hold = 1'b1;
    cycle();
    cycle();
    smu_hold = 1'b0;
    cycle();
    n_total++; if (rif16.rec_len !== 16'd2 || rif16.rec_entries !== 6'd9) begin n_bad++; $display("FAIL midrst_next got=%0d/%0d want=2/9", rif16.rec_len, rif16.rec_entries); end
    n_total++; if (ep16 !== 32'd1) begin n_bad++; $display("FAIL midrst_episode got=%0d want=1", ep16); end
  endtask

  task automatic test_release_in_hold();
    rif16.rec_ready = 1'b0;
    num_entries = 30'd4;
    pj_reset = 1'b1;
    smu_hold = 1'b1;
    cycle();
    pj_reset = 1'b0;
    cycle();
    smu_hold = 1'b0;
    cycle();
    n_total++; if (rif16.rec_valid !== 1'b1 || rif16.rec_len !== 16'd1) begin n_bad++; $display("FAIL release_rec got=%0d/%0d want=1/1", rif16.rec_valid, rif16.rec_len); end
    n_total++; if (hc16 !== 32'd1) begin n_bad++; $display("FAIL release_hold_cycles got=%0d want=1", hc16); end
  endtask

  initial begin
    rif16.rec_ready = 1'b0;
    rif4.rec_ready  = 1'b1;
    test_reset();
    test_basic();
    test_sat();
    test_back_to_back();
    test_drop();
    test_full_pop();
    test_len_sat();
    test_reset_mid();
    test_release_in_hold();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/smu_hold_tracker.md
SMU_HOLD_TRACKER -- requirements
Module: smu_hold_tracker

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: record FIFO depth; power of two, 2..16.
REQ-002 Parameter LEN_W, default 16: width of the episode-length field.
REQ-003 pj_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 pj_reset  input  1  asynchronous, active-high reset.
REQ-005 smu_hold  input  1  stack management unit hold, sampled every cycle.
REQ-006 num_entries  input  30  current stack-cache entry count.
REQ-007 rec_valid  output  1  head record available.
REQ-008 rec_ready  input  1  consumer accepts the head record.
REQ-009 rec_len  output  LEN_W  head record: hold episode length in cycles.
REQ-010 rec_entries  output  6  head record: num_entries at episode start, saturated at 63.
REQ-011 episode_count  output  32  completed episodes, including dropped episodes.
REQ-012 hold_cycles  output  32  total cycles with smu_hold=1.
REQ-013 drop_count  output  16  episodes lost to a full FIFO.

Function
REQ-014 FSM states: IDLE, HOLD.
REQ-015 IDLE & smu_hold=1 -> HOLD, with len_cnt=1 and start_entries=sat63(num_entries).
REQ-016 HOLD & smu_hold=1 -> stay in HOLD, with len_cnt incrementing and saturating at 2^LEN_W-1 (no wrap).
REQ-017 HOLD & smu_hold=0 -> IDLE, pushing {len_cnt, start_entries} to the FIFO in that same cycle.
REQ-018 A single-cycle hold (1 then 0) produces a record with rec_len=1.
REQ-019 The earliest re-entry into HOLD is the cycle after the push; back-to-back episodes each produce their own record.
REQ-020 A pushed record is visible as rec_valid=1 one cycle after the falling sample; output is registered, with no combinational input-to-output path.
REQ-021 Handshake: a pop occurs when rec_valid & rec_ready; rec_len and rec_entries stay stable while rec_valid=1 and rec_ready=0.
REQ-022 Push when the FIFO is full and no pop occurs in the same cycle: the record is dropped, and drop_count increments, saturating at 16'hFFFF.
REQ-023 Push and pop in the same cycle while full: the push is accepted, with no drop.
REQ-024 Push and pop in the same cycle while empty: the record is not bypassed; it appears the following cycle.
REQ-025 episode_count increments once per HOLD->IDLE transition, wrapping modulo 2^32.
REQ-026 hold_cycles increments each cycle smu_hold=1, wrapping modulo 2^32.
REQ-027 sat63: rec_entries=63 if num_entries>63, else num_entries[5:0].

Reset
REQ-028 Asserting pj_reset forces state=IDLE, empties the FIFO, and sets len_cnt, rec_valid, rec_len, rec_entries, episode_count, hold_cycles and drop_count to 0.
REQ-029 Reset during HOLD discards the open episode and produces no record.
REQ-030 When pj_reset deasserts while smu_hold=1, a new episode starts on the first rising edge after deassertion.

Structure
REQ-031 A shared package holds the FSM state encoding, the SAT_ENTRIES=63 constant and the record field widths.
REQ-032 The FIFO is one sub-module, smu_hold_rec_fifo, with push/pop/full/empty and registered head output; the FSM and counters live in the top module.

Verification
REQ-033 smu_hold high for 5 cycles with num_entries=20, rec_ready=1 -> one record {len=5, entries=20}, episode_count=1, hold_cycles=5.
REQ-034 Single-cycle pulse with num_entries=100 -> record {len=1, entries=63}.
REQ-035 rec_ready=0, six 2-cycle episodes with FIFO_DEPTH=4 -> rec_valid=1, first 4 records retained in order, drop_count=2, episode_count=6.
REQ-036 LEN_W=4, hold for 20 cycles -> rec_len=15, hold_cycles=20.
REQ-037 FIFO full, with an episode ending in the same cycle as rec_ready=1 -> no drop, 4 records remain after the pop.
REQ-038 pj_reset pulsed mid-HOLD after 3 cycles -> all outputs 0, no record emitted; the next 2-cycle hold yields rec_len=2.
